// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: code widths, blank code and hex glyph table.
// Segment codes are {g,f,e,d,c,b,a}, active-low (0 lights a segment).
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Glyphs 0-9 then A, b, C, d, E, F.
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Nibble to active-low segment code.
    function automatic logic [SEG_W-1:0] seg_lookup(input logic [NIB_W-1:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Display bus for seg7_scan_mux.
// master: drives value/dp_in/digit_en/lz_suppress, observes seg/dp/anode/frame_tick.
// slave : the scan multiplexer itself.
interface seg7_scan_mux_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;        // nibble i = value[4i+3:4i]
    logic [DIGITS-1:0]   dp_in;        // decimal point request per digit, active-high
    logic [DIGITS-1:0]   digit_en;     // per-digit enable, 0 blanks the digit
    logic                lz_suppress;  // leading-zero suppression enable
    logic [6:0]          seg;          // {g,f,e,d,c,b,a}, active-low
    logic                dp;           // decimal point segment, active-low
    logic [DIGITS-1:0]   anode;        // digit select, active-low
    logic                frame_tick;   // one-cycle pulse after each shadow load

    modport master (
        output value, dp_in, digit_en, lz_suppress,
        input  seg, dp, anode, frame_tick
    );

    modport slave (
        input  value, dp_in, digit_en, lz_suppress,
        output seg, dp, anode, frame_tick
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Ports: nibble_i - 4-bit value; seg_c_o - {g,f,e,d,c,b,a} active-low code.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    output logic [SEG_W-1:0] seg_c_o
);

    assign seg_c_o = seg_lookup(nibble_i);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment display driver.
// Each digit owns a slot of DIV clocks; the first BLANK clocks of a slot keep
// all anodes off to avoid ghosting. Inputs are captured into shadow registers
// once per frame so a frame never mixes old and new data.
// Ports: clk, rst (async, active-high); bus (slave) carries value, dp_in,
// digit_en, lz_suppress in and registered seg, dp, anode, frame_tick out.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 4000,
    parameter int unsigned BLANK  = 16
) (
    input  logic            clk,
    input  logic            rst,
    seg7_scan_mux_if.slave  bus
);

    localparam int unsigned PC_W  = $clog2(DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = NIB_W * DIGITS;

    // Scan position
    logic [PC_W-1:0]   pc_q,  pc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Shadow copies of the display inputs
    logic [VAL_W-1:0]  sh_value_q, sh_value_d;
    logic [DIGITS-1:0] sh_dp_q,    sh_dp_d;
    logic [DIGITS-1:0] sh_en_q,    sh_en_d;
    logic              sh_lz_q,    sh_lz_d;

    // Registered outputs
    logic [SEG_W-1:0]  seg_q,   seg_d;
    logic              dp_q,    dp_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic              tick_q,  tick_d;

    // Per-slot selections
    logic              load;
    logic [NIB_W-1:0]  nib_sel;
    logic              en_sel;
    logic              dp_sel;
    logic              zero_sel;
    logic [DIGITS:0]   zero_from;   // zero_from[i]: nibbles i..DIGITS-1 are all zero
    logic [SEG_W-1:0]  glyph;

    seg7_decode u_decode (
        .nibble_i (nib_sel),
        .seg_c_o  (glyph)
    );

    // Prescaler, digit index and once-per-frame shadow capture
    always_comb begin
        load = (pc_q == '0) && (idx_q == '0);

        pc_d  = pc_q + PC_W'(1);
        idx_d = idx_q;
        if (pc_q == PC_W'(DIV - 1)) begin
            pc_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        sh_value_d = sh_value_q;
        sh_dp_d    = sh_dp_q;
        sh_en_d    = sh_en_q;
        sh_lz_d    = sh_lz_q;
        if (load) begin
            sh_value_d = bus.value;
            sh_dp_d    = bus.dp_in;
            sh_en_d    = bus.digit_en;
            sh_lz_d    = bus.lz_suppress;
        end

        tick_d = load;
    end

    // Select the current digit's data. The next shadow is used so that with
    // BLANK = 0 the first slot of a frame already shows the freshly loaded data.
    always_comb begin
        nib_sel   = '0;
        en_sel    = 1'b0;
        dp_sel    = 1'b0;
        zero_sel  = 1'b0;
        zero_from = '0;

        zero_from[DIGITS] = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (sh_value_d[NIB_W*i +: NIB_W] == '0);
        end

        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel  = sh_value_d[NIB_W*i +: NIB_W];
                en_sel   = sh_en_d[i];
                dp_sel   = sh_dp_d[i];
                zero_sel = zero_from[i];
            end
        end
    end

    // Output pattern for the current scan position
    always_comb begin
        anode_d = '1;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;

        if (pc_q >= PC_W'(BLANK)) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                anode_d[i] = (idx_q != IDX_W'(i));
            end
            if (en_sel) begin
                dp_d = ~dp_sel;
                // Leading-zero suppression blanks the glyph only, never digit 0
                if (sh_lz_d && (idx_q != '0) && zero_sel) begin
                    seg_d = SEG_OFF;
                end else begin
                    seg_d = glyph;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            idx_q      <= '0;
            sh_value_q <= '0;
            sh_dp_q    <= '0;
            sh_en_q    <= '0;
            sh_lz_q    <= 1'b0;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            anode_q    <= '1;
            tick_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            idx_q      <= idx_d;
            sh_value_q <= sh_value_d;
            sh_dp_q    <= sh_dp_d;
            sh_en_q    <= sh_en_d;
            sh_lz_q    <= sh_lz_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            anode_q    <= anode_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.anode      = anode_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (DIGITS=4, DIV=8, BLANK=2).
module tb_seg7_scan_mux;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int F      = DIGITS * DIV;

    logic clk;
    logic rst;

    seg7_scan_mux_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_mux #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since reset release and the frame's captured inputs
    int          mc;
    logic [15:0] sh_v;
    logic [3:0]  sh_dp, sh_en;
    logic        sh_lz;
    logic [6:0]  gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [3:0] exp_anode, obs_anode;
    logic [6:0] exp_seg, obs_seg;
    logic       exp_dp, obs_dp, exp_tick, obs_tick;

    task automatic model_reset();
        mc = 0; sh_v = '0; sh_dp = '0; sh_en = '0; sh_lz = 1'b0;
    endtask

    // One clock: model the expected outputs from the scan rules, then sample the DUT.
    task automatic step();
        int pc, idx;
        logic [15:0] hi;
        @(posedge clk);
        if (mc % F == 0) begin
            sh_v = bus.value; sh_dp = bus.dp_in; sh_en = bus.digit_en; sh_lz = bus.lz_suppress;
        end
        pc  = mc % DIV;
        idx = (mc / DIV) % DIGITS;
        exp_tick  = (mc % F == 0);
        exp_anode = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        if (pc >= BLANK) begin
            exp_anode[idx] = 1'b0;
            if (sh_en[idx]) begin
                exp_dp = ~sh_dp[idx];
                hi = sh_v >> (4 * idx);
                if (!(sh_lz && idx > 0 && hi == 16'h0)) exp_seg = gl[sh_v[4*idx +: 4]];
            end
        end
        mc++;
        #2;
        obs_anode = bus.anode; obs_seg = bus.seg; obs_dp = bus.dp; obs_tick = bus.frame_tick;
    endtask

    task automatic sync_frame();
        while (mc % F != 0) step();
    endtask

    function automatic int lit_digit(input logic [3:0] an);
        int d = -1;
        for (int j = 0; j < DIGITS; j++) if (an == ~(4'b0001 << j)) d = j;
        return d;
    endfunction

    task automatic set_inputs(input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] en,
                              input logic lz);
        bus.value = v; bus.dp_in = dpi; bus.digit_en = en; bus.lz_suppress = lz;
    endtask

    task automatic test_reset();
        set_inputs(16'h1595, 4'h0, 4'hF, 1'b0);
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.anode, bus.seg, bus.dp, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_initial anode=%b seg=%h dp=%b tick=%b want F/7f/1/0",
                     bus.anode, bus.seg, bus.dp, bus.frame_tick);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        step();
        checks++;
        if (obs_tick !== 1'b1) begin
            errors++; $display("FAIL first_tick got=%b want=1", obs_tick);
        end
        step();
        checks++;
        if (obs_tick !== 1'b0) begin
            errors++; $display("FAIL tick_width got=%b want=0", obs_tick);
        end
        for (int k = 0; k < 11; k++) begin
            step();
            checks++;
            if ({obs_anode, obs_seg, obs_dp, obs_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
                errors++;
                $display("FAIL reset_run mc=%0d anode=%b/%b seg=%h/%h dp=%b/%b tick=%b/%b", mc,
                         obs_anode, exp_anode, obs_seg, exp_seg, obs_dp, exp_dp, obs_tick, exp_tick);
            end
        end
        // Mid-slot reset: outputs must go off within the same cycle
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.anode, bus.seg, bus.dp, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_async anode=%b seg=%h dp=%b tick=%b want F/7f/1/0",
                     bus.anode, bus.seg, bus.dp, bus.frame_tick);
        end
        repeat (3) begin
            @(posedge clk);
            #2;
            checks++;
            if ({bus.anode, bus.seg, bus.dp, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold anode=%b seg=%h dp=%b tick=%b want F/7f/1/0",
                         bus.anode, bus.seg, bus.dp, bus.frame_tick);
            end
        end
        rst = 1'b0;
        model_reset();
        step();
        checks++;
        if (obs_tick !== 1'b1) begin
            errors++; $display("FAIL restart_tick got=%b want=1", obs_tick);
        end
    endtask

    task automatic test_scan();
        logic [6:0] want [4];
        int low_cnt [4];
        int d;
        want = '{7'h12, 7'h10, 7'h12, 7'h79};
        low_cnt = '{0, 0, 0, 0};
        set_inputs(16'h1595, 4'h0, 4'hF, 1'b0);
        sync_frame();
        for (int k = 0; k < F; k++) begin
            step();
            checks++;
            if ({obs_anode, obs_seg, obs_dp, obs_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
                errors++;
                $display("FAIL scan_model mc=%0d anode=%b/%b seg=%h/%h dp=%b/%b tick=%b/%b", mc,
                         obs_anode, exp_anode, obs_seg, exp_seg, obs_dp, exp_dp, obs_tick, exp_tick);
            end
            d = lit_digit(obs_anode);
            if (d >= 0) begin
                low_cnt[d]++;
                checks++;
                if (obs_seg !== want[d]) begin
                    errors++; $display("FAIL scan_seg digit=%0d got=%h want=%h", d, obs_seg, want[d]);
                end
            end
        end
        for (int j = 0; j < DIGITS; j++) begin
            checks++;
            if (low_cnt[j] != DIV - BLANK) begin
                errors++; $display("FAIL scan_on_time digit=%0d got=%0d want=%0d", j, low_cnt[j], DIV - BLANK);
            end
        end
    endtask

    task automatic test_hex_dp();
        logic [6:0] want [4];
        logic want_dp [4];
        int d;
        want = '{7'h21, 7'h46, 7'h03, 7'h08};
        want_dp = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_inputs(16'hABCD, 4'b0101, 4'hF, 1'b0);
        sync_frame();
        for (int k = 0; k < F; k++) begin
            step();
            checks++;
            if ({obs_anode, obs_seg, obs_dp, obs_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
                errors++;
                $display("FAIL hex_model mc=%0d anode=%b/%b seg=%h/%h dp=%b/%b tick=%b/%b", mc,
                         obs_anode, exp_anode, obs_seg, exp_seg, obs_dp, exp_dp, obs_tick, exp_tick);
            end
            d = lit_digit(obs_anode);
            if (d >= 0) begin
                checks++;
                if ({obs_seg, obs_dp} !== {want[d], want_dp[d]}) begin
                    errors++;
                    $display("FAIL hex_dp digit=%0d seg=%h dp=%b want seg=%h dp=%b", d, obs_seg, obs_dp,
                             want[d], want_dp[d]);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] want [4];
        logic [15:0] vals [2];
        int d;
        vals = '{16'h0030, 16'h0000};
        for (int p = 0; p < 2; p++) begin
            if (p == 0) want = '{7'h40, 7'h30, 7'h7F, 7'h7F};
            else        want = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
            set_inputs(vals[p], 4'h0, 4'hF, 1'b1);
            sync_frame();
            for (int k = 0; k < F; k++) begin
                step();
                checks++;
                if ({obs_anode, obs_seg, obs_dp, obs_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
                    errors++;
                    $display("FAIL lz_model mc=%0d anode=%b/%b seg=%h/%h dp=%b/%b tick=%b/%b", mc,
                             obs_anode, exp_anode, obs_seg, exp_seg, obs_dp, exp_dp, obs_tick, exp_tick);
                end
                d = lit_digit(obs_anode);
                if (d >= 0) begin
                    checks++;
                    if (obs_seg !== want[d]) begin
                        errors++;
                        $display("FAIL lz_seg value=%h digit=%0d got=%h want=%h", vals[p], d, obs_seg, want[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_no_tearing();
        bit seen = 0;
        set_inputs(16'h1111, 4'h0, 4'hF, 1'b0);
        sync_frame();
        step();
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (lit_digit(obs_anode) >= 0 && obs_seg !== 7'h79) begin
                errors++; $display("FAIL tear_old mc=%0d got=%h want=79", mc, obs_seg);
            end
        end
        bus.value = 16'h2222;
        for (int k = 0; k < 2 * F && !seen; k++) begin
            step();
            checks++;
            if ({obs_anode, obs_seg, obs_dp, obs_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
                errors++;
                $display("FAIL tear_model mc=%0d anode=%b/%b seg=%h/%h dp=%b/%b tick=%b/%b", mc,
                         obs_anode, exp_anode, obs_seg, exp_seg, obs_dp, exp_dp, obs_tick, exp_tick);
            end
            if (obs_tick === 1'b1) seen = 1;
            else if (lit_digit(obs_anode) >= 0 && obs_seg !== 7'h79) begin
                errors++; $display("FAIL tear_hold mc=%0d got=%h want=79", mc, obs_seg);
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL tear_tick_timeout got=0 want=1 within %0d cycles", 2 * F);
        end
        for (int k = 0; k < F; k++) begin
            step();
            checks++;
            if (lit_digit(obs_anode) >= 0 && obs_seg !== 7'h24) begin
                errors++; $display("FAIL tear_new mc=%0d got=%h want=24", mc, obs_seg);
            end
        end
    endtask

    task automatic test_digit_en();
        int d;
        set_inputs(16'($urandom), 4'hF, 4'b1011, 1'b0);
        sync_frame();
        for (int k = 0; k < F; k++) begin
            step();
            checks++;
            if ({obs_anode, obs_seg, obs_dp, obs_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
                errors++;
                $display("FAIL en_model mc=%0d anode=%b/%b seg=%h/%h dp=%b/%b tick=%b/%b", mc,
                         obs_anode, exp_anode, obs_seg, exp_seg, obs_dp, exp_dp, obs_tick, exp_tick);
            end
            d = lit_digit(obs_anode);
            if (d >= 0) begin
                checks++;
                if (d == 2 && {obs_seg, obs_dp} !== {7'h7F, 1'b1}) begin
                    errors++; $display("FAIL en_blank seg=%h dp=%b want 7f/1", obs_seg, obs_dp);
                end else if (d != 2 && obs_dp !== 1'b0) begin
                    errors++; $display("FAIL en_dp digit=%0d got=%b want=0", d, obs_dp);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8 * F; k++) begin
            if ($urandom_range(7) == 0)
                set_inputs(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            if ($urandom_range(15) == 0) bus.value[15:8] = 8'h00;
            step();
            checks++;
            if ({obs_anode, obs_seg, obs_dp, obs_tick} !== {exp_anode, exp_seg, exp_dp, exp_tick}) begin
                errors++;
                $display("FAIL rand_model mc=%0d anode=%b/%b seg=%h/%h dp=%b/%b tick=%b/%b", mc,
                         obs_anode, exp_anode, obs_seg, exp_seg, obs_dp, exp_dp, obs_tick, exp_tick);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        model_reset();
        test_reset();
        test_scan();
        test_hex_dp();
        test_lz();
        test_no_tearing();
        test_digit_en();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter DIV, default 4000, meaning clk cycles per digit slot; legal range DIV >= 4.
REQ-003 SHALL have parameter BLANK, default 16, meaning clk cycles at the start of each slot with all anodes off; legal range 0 <= BLANK < DIV.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port value  input  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i].
REQ-007 SHALL have port dp_in  input  DIGITS  decimal point request per digit, active-high.
REQ-008 SHALL have port digit_en  input  DIGITS  per-digit enable; 0 blanks that digit.
REQ-009 SHALL have port lz_suppress  input  1  leading-zero suppression enable.
REQ-010 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp  output  1  decimal point segment, active-low.
REQ-012 SHALL have port anode  output  DIGITS  digit select, active-low, one-hot-low or all-high.
REQ-013 SHALL have port frame_tick  output  1  one-cycle pulse marking a shadow-register load.

Function
REQ-014 SHALL run prescaler pc counting 0..DIV-1, wrapping to 0; on wrap, digit index idx SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-015 SHALL load shadow copies of value, dp_in, digit_en, lz_suppress in any cycle where pc==0 and idx==0; inputs SHALL NOT affect outputs at any other time (no tearing within a frame).
REQ-016 SHALL assert frame_tick for exactly one cycle, in the cycle after each shadow load.
REQ-017 SHALL drive anode all-high while pc < BLANK; for pc >= BLANK, anode[idx] = 0 and all other bits 1.
REQ-018 SHALL display shadow nibble idx on anode[idx]; decode 0-9 and A-F (A,b,C,d,E,F glyphs) per the shared table.
REQ-019 SHALL blank a digit (seg = 7'h7F, dp = 1) when its shadow digit_en bit is 0.
REQ-020 SHALL, when shadow lz_suppress = 1, blank digit i (i > 0) if nibble i and all nibbles above i are zero; digit 0 SHALL never be suppressed.
REQ-021 SHALL drive dp = ~dp_in_shadow[idx] unless the digit is blanked per REQ-019; LZ suppression SHALL NOT blank dp.
REQ-022 SHALL register seg, dp, anode, frame_tick; outputs reflect pc/idx/shadow state with exactly one clk of latency.
REQ-023 SHALL keep seg and dp at 7'h7F/1 while anode is all-high (blank interval).
REQ-024 SHALL, for DIGITS = 1, keep idx at 0 and reload the shadow every DIV cycles.

Reset
REQ-025 SHALL, while rst = 1, force pc = 0, idx = 0, shadow = 0, anode all-high, seg = 7'h7F, dp = 1, frame_tick = 0, regardless of clk.
REQ-026 SHALL, on the first clk edge after rst deasserts, load the shadow (pc==0, idx==0) and pulse frame_tick one cycle later.
REQ-027 SHALL, on rst asserted mid-slot or mid-frame, abandon the frame and restart per REQ-026 without emitting a partial frame_tick.

Structure
REQ-028 SHALL place in shared package seg7_pkg: 16-entry active-low segment code table, SEG_OFF = 7'h7F constant.
REQ-029 SHALL instantiate one combinational sub-module seg7_decode (4-bit nibble in, 7-bit active-low code out) using seg7_pkg.
REQ-030 SHALL size pc as $clog2(DIV) bits and idx as max(1, $clog2(DIGITS)) bits.

Verification (bench: DIGITS=4, DIV=8, BLANK=2)
REQ-031 SHALL check reset: rst=1 mid-slot -> same cycle anode=4'hF, seg=7'h7F, dp=1; release -> frame_tick at cycle 2 after release.
REQ-032 SHALL check scan: value=16'h1595, all enabled -> anode sequence 1110,1101,1011,0111 each low 6 of 8 cycles, seg 7'h12,7'h10,7'h12,7'h79.
REQ-033 SHALL check hex/dp: value=16'hAbCd... i.e. 16'hABCD, dp_in=4'b0101 -> seg codes for d,C,b,A on digits 0..3, dp=0 on digits 0 and 2 only.
REQ-034 SHALL check LZ: value=16'h0030, lz_suppress=1 -> digits 3,2 blank, digit 1 shows 3, digit 0 shows 0; value=0 -> only digit 0 lit.
REQ-035 SHALL check no tearing: change value mid-frame from 16'h1111 to 16'h2222 -> all four digits show 1 until next frame_tick, then all show 2.
REQ-036 SHALL check digit_en=4'b1011 with dp_in=4'hF -> digit 2 slot has seg=7'h7F, dp=1 while anode=1011.
